// File: rtl/corescore_uart_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART emitter between N_REQ requesters.
// Ownership is held for a whole message and ends on EOM_CHAR or when the owner stalls too long.
module corescore_uart_arbiter #(
   parameter int         N_REQ        = 4,
   parameter logic [7:0] EOM_CHAR     = 8'h0A,
   parameter int         IDLE_TIMEOUT = 1024
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N_REQ-1:0]   i_valid,
   input  logic [8*N_REQ-1:0] i_data,
   output logic [N_REQ-1:0]   o_ready,
   output logic [7:0]         o_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [N_REQ-1:0]   o_grant,
   output logic               o_busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) + 1 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         data_q, data_d;
   logic               valid_q, valid_d;

   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_found;
   logic [7:0]         own_data;
   logic               own_valid;
   logic               can_load;
   logic               up_xfer;
   logic               release_now;

   assign own_data  = i_data[{gnt_q, 3'b000} +: 8];
   assign own_valid = i_valid[gnt_q];
   assign can_load  = (state_q == ST_GRANT) && (!valid_q || i_ready);
   assign up_xfer   = can_load && own_valid;

   // Search starts at rr_q and wraps, so the most recent owner is tried last.
   always_comb begin
      cand      = '0;
      arb_idx   = '0;
      arb_found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = IDX_W'((int'(rr_q) + i) % N_REQ);
         if (!arb_found && i_valid[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      rr_d        = rr_q;
      cnt_d       = cnt_q;
      release_now = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               state_d = ST_GRANT;
               gnt_d   = arb_idx;
               cnt_d   = '0;
            end
         end
         ST_GRANT: begin
            if (up_xfer) begin
               cnt_d       = '0;
               release_now = (own_data == EOM_CHAR);
            end else begin
               release_now = (IDLE_TIMEOUT != 0) && (cnt_q == CNT_LAST);
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
            if (release_now) begin
               state_d = ST_IDLE;
               rr_d    = (gnt_q == IDX_LAST) ? '0 : gnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (up_xfer) begin
         data_d  = own_data;
         valid_d = 1'b1;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_comb begin
      o_grant = '0;
      o_ready = '0;
      if (state_q == ST_GRANT) begin
         o_grant[gnt_q] = 1'b1;
         o_ready[gnt_q] = can_load;
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_busy  = (state_q == ST_GRANT) || valid_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_corescore_uart_arbiter.sv
// Bench for corescore_uart_arbiter: directed scenarios plus a random phase, each cycle
// compared against a behavioural model of the message-locked round-robin sharing rules.
module tb_corescore_uart_arbiter;

   localparam int         N   = 4;
   localparam int         TO  = 8;
   localparam logic [7:0] EOM = 8'h0A;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   valid;
   logic [8*N-1:0] data;
   logic [N-1:0]   ready;
   logic [7:0]     odata;
   logic           ovalid;
   logic           iready;
   logic [N-1:0]   grant;
   logic           busy;

   always #5 clk = ~clk;

   corescore_uart_arbiter #(.N_REQ(N), .EOM_CHAR(EOM), .IDLE_TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .o_ready(ready),
      .o_data(odata), .o_valid(ovalid), .i_ready(iready), .o_grant(grant), .o_busy(busy)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] txq [N][$];
   logic [N-1:0] en;
   logic [7:0] exp_q[$];
   logic [7:0] out_log[$];
   logic [7:0] ref_log[$];
   int glog[$];
   logic [N-1:0] prev_grant;

   // model: owner index (-1 = nobody), round-robin start, stall count, output slot
   int m_owner, m_rr, m_cnt;
   logic m_ov;
   logic [7:0] m_od;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_rr = 0; m_cnt = 0; m_ov = 1'b0; m_od = 8'h00;
      exp_q.delete();
      prev_grant = '0;
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         valid[k] = en[k] && (txq[k].size() > 0);
         data[8*k +: 8] = valid[k] ? txq[k][0] : 8'($urandom);
      end
   endtask

   task automatic rand_msg(int k, int len);
      logic [7:0] b;
      for (int i = 0; i < len - 1; i++) begin
         b = 8'($urandom);
         if (b == EOM) b = 8'h55;
         txq[k].push_back(b);
         ref_log.push_back(b);
      end
      txq[k].push_back(EOM);
      ref_log.push_back(EOM);
   endtask

   task automatic cycle();
      logic [N-1:0] exp_grant, exp_rdy;
      logic can, acc;
      logic [7:0] b;
      int old_owner;
      drive();
      #2;
      exp_grant = '0;
      if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
      can = (m_owner >= 0) && (!m_ov || iready);
      exp_rdy = can ? exp_grant : '0;
      chk("grant", 32'(grant), 32'(exp_grant));
      chk("ready", 32'(ready), 32'(exp_rdy));
      chk("o_valid", 32'(ovalid), 32'(m_ov));
      chk("o_data", 32'(odata), 32'(m_od));
      chk("busy", 32'(busy), 32'((m_owner >= 0) || m_ov));
      if (m_ov && iready) begin
         out_log.push_back(odata);
         chk("stream_nonempty", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) chk("stream_byte", 32'(odata), 32'(exp_q.pop_front()));
      end
      if (grant != '0 && prev_grant == '0)
         for (int k = 0; k < N; k++) if (grant[k]) glog.push_back(k);
      prev_grant = grant;

      old_owner = m_owner;
      acc = can && valid[m_owner];
      b = acc ? data[8*m_owner +: 8] : 8'h00;
      if (acc) begin
         exp_q.push_back(b);
         m_ov = 1'b1;
         m_od = b;
      end else if (iready) begin
         m_ov = 1'b0;
      end
      if (m_owner < 0) begin
         for (int i = 0; i < N; i++)
            if (m_owner < 0 && valid[(m_rr + i) % N]) begin
               m_owner = (m_rr + i) % N;
               m_cnt = 0;
            end
      end else if (acc) begin
         m_cnt = 0;
         if (b == EOM) begin m_rr = (m_owner + 1) % N; m_owner = -1; end
      end else if (m_cnt == TO - 1) begin
         m_rr = (m_owner + 1) % N; m_owner = -1;
      end else begin
         m_cnt++;
      end
      @(posedge clk);
      #1;
      if (acc) void'(txq[old_owner].pop_front());
   endtask

   function automatic bit all_idle();
      bit r;
      r = (m_owner < 0) && !m_ov;
      for (int k = 0; k < N; k++) if (txq[k].size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic run_until_idle(int limit);
      int n;
      n = 0;
      while (!all_idle() && n < limit) begin cycle(); n++; end
      chk("drain_in_budget", 32'(all_idle()), 32'd1);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_o_valid", 32'(ovalid), 32'd0);
      chk("rst_o_grant", 32'(grant), 32'd0);
      chk("rst_o_ready", 32'(ready), 32'd0);
      chk("rst_o_busy", 32'(busy), 32'd0);
      for (int k = 0; k < N; k++) txq[k].delete();
      en = '1;
      model_reset();
      drive();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_log.delete();
      ref_log.delete();
      glog.delete();
   endtask

   initial begin
      int n;
      rst = 1'b1; iready = 1'b0; valid = '0; data = '0; en = '1;
      model_reset();
      #1;
      chk("init_o_valid", 32'(ovalid), 32'd0);
      chk("init_o_data", 32'(odata), 32'd0);
      chk("init_o_grant", 32'(grant), 32'd0);
      chk("init_o_ready", 32'(ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // async reset while a byte is buffered
      iready = 1'b0;
      rand_msg(1, 4);
      repeat (3) cycle();
      chk("t1_buffered", 32'(ovalid), 32'd1);
      do_reset();

      // single message with full-rate emitter
      iready = 1'b1;
      txq[0].push_back(8'h41); txq[0].push_back(8'h42); txq[0].push_back(8'h0A);
      cycle();
      chk("t2_arb_cycle_grant", 32'(grant), 32'b0001);
      run_until_idle(50);
      chk("t2_len", 32'(out_log.size()), 32'd3);
      if (out_log.size() == 3) begin
         chk("t2_b0", 32'(out_log[0]), 32'h41);
         chk("t2_b1", 32'(out_log[1]), 32'h42);
         chk("t2_b2", 32'(out_log[2]), 32'h0A);
      end
      chk("t2_grant_end", 32'(grant), 32'd0);

      // contention: req0 has two messages queued, req2 one
      do_reset();
      iready = 1'b1;
      rand_msg(0, 4);
      rand_msg(2, 3);
      rand_msg(0, 2);
      begin
         logic [7:0] m0a[$], m2[$], m0b[$];
         for (int i = 0; i < 4; i++) m0a.push_back(ref_log[i]);
         for (int i = 4; i < 7; i++) m2.push_back(ref_log[i]);
         for (int i = 7; i < 9; i++) m0b.push_back(ref_log[i]);
         ref_log = {m0a, m2, m0b};
      end
      run_until_idle(100);
      chk("t3_glog_len", 32'(glog.size()), 32'd3);
      if (glog.size() == 3) begin
         chk("t3_g0", 32'(glog[0]), 32'd0);
         chk("t3_g1", 32'(glog[1]), 32'd2);
         chk("t3_g2", 32'(glog[2]), 32'd0);
      end
      chk("t3_len", 32'(out_log.size()), 32'(ref_log.size()));
      for (int i = 0; i < out_log.size() && i < ref_log.size(); i++)
         chk("t3_order", 32'(out_log[i]), 32'(ref_log[i]));

      // emitter back-pressure for 20 cycles
      do_reset();
      iready = 1'b1;
      rand_msg(0, 6);
      repeat (3) cycle();
      iready = 1'b0;
      begin
         logic [7:0] held;
         held = odata;
         chk("t4_valid_at_hold", 32'(ovalid), 32'd1);
         repeat (20) begin
            cycle();
            chk("t4_hold_data", 32'(odata), 32'(held));
            chk("t4_hold_ready", 32'(ready), 32'd0);
         end
      end
      iready = 1'b1;
      run_until_idle(200);
      chk("t4_len", 32'(out_log.size()), 32'(ref_log.size()));
      for (int i = 0; i < out_log.size() && i < ref_log.size(); i++)
         chk("t4_order", 32'(out_log[i]), 32'(ref_log[i]));

      // owner stalls after one byte without EOM, req1 waiting
      do_reset();
      iready = 1'b1;
      txq[0].push_back(8'h41);
      rand_msg(1, 3);
      n = 0;
      while (txq[0].size() != 0 && n < 20) begin cycle(); n++; end
      chk("t5_accepted", 32'(txq[0].size()), 32'd0);
      n = 0;
      while (grant == 4'b0001 && n < 30) begin cycle(); n++; end
      chk("t5_stall_cycles", 32'(n), 32'(TO));
      chk("t5_released", 32'(grant), 32'd0);
      cycle();
      chk("t5_next_owner", 32'(grant), 32'b0010);
      run_until_idle(50);

      // all requesters stream 3-byte messages
      do_reset();
      iready = 1'b1;
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < N; k++) rand_msg(k, 3);
      run_until_idle(400);
      chk("t6_glog_len", 32'(glog.size()), 32'(3 * N));
      for (int i = 0; i < glog.size(); i++) chk("t6_rotation", 32'(glog[i]), 32'(i % N));

      // random traffic, back-pressure and stalls
      do_reset();
      for (int c = 0; c < 600; c++) begin
         iready = ($urandom_range(0, 9) < 7);
         for (int k = 0; k < N; k++) begin
            if (txq[k].size() == 0 && $urandom_range(0, 3) == 0) rand_msg(k, $urandom_range(1, 5));
            if ($urandom_range(0, 29) == 0) en[k] = ~en[k];
         end
         cycle();
      end
      en = '1;
      iready = 1'b1;
      run_until_idle(500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
